// File: rtl/mcss_stream.sv
// Per-lane maximum contiguous subarray sum over fixed-length frames.
// Optional MCSS_INDEX_EN adds per-lane subarray start/end tracking.
module mcss_stream #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int FRAME_LEN = 256,
  localparam int IDX_W = $clog2(FRAME_LEN),
  localparam int ACC_W = WIDTH + IDX_W,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   out_sum,
  output logic [ACC_W-1:0]         out_best_sum,
  output logic [LANE_W-1:0]        out_best_lane
`ifdef MCSS_INDEX_EN
  ,
  output logic [LANES*IDX_W-1:0]   out_start,
  output logic [LANES*IDX_W-1:0]   out_end
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] idx;
  logic last, accept, load;

  logic signed [ACC_W-1:0] x_s    [LANES];
  logic signed [ACC_W-1:0] cur_q  [LANES];
  logic signed [ACC_W-1:0] best_q [LANES];
  logic signed [ACC_W-1:0] cur_d  [LANES];
  logic signed [ACC_W-1:0] best_d [LANES];
  logic signed [ACC_W-1:0] res_sum[LANES];
  logic signed [ACC_W-1:0] bsum_d;
  logic [LANE_W-1:0]       blane_d;

  assign last     = idx == LAST;
  // Only the closing beat stalls behind a pending result
  assign in_ready = !rst && !(out_valid && !out_ready && last);
  assign accept   = in_valid && in_ready && !clear;
  assign load     = accept && last;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      x_s[l] = {{IDX_W{in_data[l*WIDTH+WIDTH-1]}},
                in_data[l*WIDTH +: WIDTH]};
      cur_d[l]  = cur_q[l];
      best_d[l] = best_q[l];
      if (idx == '0) begin
        cur_d[l]  = x_s[l];
        best_d[l] = x_s[l];
      end else begin
        if (cur_q[l] < 0) cur_d[l] = x_s[l];
        else cur_d[l] = cur_q[l] + x_s[l];
        if (cur_d[l] > best_q[l]) best_d[l] = cur_d[l];
      end
    end
  end

  // Strict compare keeps the lowest lane on ties
  always_comb begin
    bsum_d  = best_d[0];
    blane_d = '0;
    for (int l = 1; l < LANES; l++) begin
      if (best_d[l] > bsum_d) begin
        bsum_d  = best_d[l];
        blane_d = LANE_W'(l);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      for (int l = 0; l < LANES; l++) begin
        cur_q[l]  <= '0;
        best_q[l] <= '0;
      end
    end else if (clear) begin
      idx <= '0;
      for (int l = 0; l < LANES; l++) begin
        cur_q[l]  <= '0;
        best_q[l] <= '0;
      end
    end else if (accept) begin
      idx <= last ? '0 : idx + 1'b1;
      for (int l = 0; l < LANES; l++) begin
        cur_q[l]  <= cur_d[l];
        best_q[l] <= best_d[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_best_sum  <= '0;
      out_best_lane <= '0;
      for (int l = 0; l < LANES; l++) res_sum[l] <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_best_sum  <= bsum_d;
      out_best_lane <= blane_d;
      for (int l = 0; l < LANES; l++) res_sum[l] <= best_d[l];
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
      out_best_sum  <= '0;
      out_best_lane <= '0;
      for (int l = 0; l < LANES; l++) res_sum[l] <= '0;
    end
  end

  always_comb begin
    out_sum = '0;
    for (int l = 0; l < LANES; l++)
      out_sum[l*ACC_W +: ACC_W] = res_sum[l];
  end

`ifdef MCSS_INDEX_EN
  logic [IDX_W-1:0] cs_q[LANES], bs_q[LANES], be_q[LANES];
  logic [IDX_W-1:0] cs_d[LANES], bs_d[LANES], be_d[LANES];
  logic [IDX_W-1:0] res_st[LANES], res_en[LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cs_d[l] = cs_q[l];
      bs_d[l] = bs_q[l];
      be_d[l] = be_q[l];
      if (idx == '0) begin
        cs_d[l] = '0;
        bs_d[l] = '0;
        be_d[l] = '0;
      end else begin
        if (cur_q[l] < 0) cs_d[l] = idx;
        if (cur_d[l] > best_q[l]) begin
          bs_d[l] = cs_d[l];
          be_d[l] = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        cs_q[l] <= '0; bs_q[l] <= '0; be_q[l] <= '0;
        res_st[l] <= '0; res_en[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (clear) begin
          cs_q[l] <= '0; bs_q[l] <= '0; be_q[l] <= '0;
        end else if (accept) begin
          cs_q[l] <= cs_d[l]; bs_q[l] <= bs_d[l]; be_q[l] <= be_d[l];
        end
        if (load) begin
          res_st[l] <= bs_d[l];
          res_en[l] <= be_d[l];
        end else if (out_valid && out_ready) begin
          res_st[l] <= '0;
          res_en[l] <= '0;
        end
      end
    end
  end

  always_comb begin
    out_start = '0;
    out_end   = '0;
    for (int l = 0; l < LANES; l++) begin
      out_start[l*IDX_W +: IDX_W] = res_st[l];
      out_end[l*IDX_W +: IDX_W]   = res_en[l];
    end
  end
`endif

endmodule
